// File: rtl/speicher_pkg.sv
// Shared types and constants for the memory-port arbiter.
package speicher_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 32;
  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FERTIG = 2'd2
  } zustand_t;

  typedef enum logic [1:0] {
    BEFEHL          = 2'd0,
    DATEN_LADEN     = 2'd1,
    DATEN_SPEICHERN = 2'd2,
    EXTERN          = 2'd3
  } anfrager_t;

endpackage

// File: rtl/speicher_prioritaet.sv
// Fixed-priority requester selection with a starvation counter for the
// external master. Only counts while the arbiter is able to grant.
module speicher_prioritaet
  import speicher_pkg::*;
#(
  parameter int HUNGER_LIMIT = 4
) (
  input  logic      Clock,
  input  logic      Reset,
  input  logic      Arbitrieren,
  input  logic      BefehlAnfrage,
  input  logic      DatenLadeAnfrage,
  input  logic      DatenSpeicherAnfrage,
  input  logic      ExternAnfrage,
  output anfrager_t Gewinner,
  output logic      GrantGueltig
);

  localparam int HW = (HUNGER_LIMIT < 1) ? 1 : $clog2(HUNGER_LIMIT + 1);
  localparam logic [HW-1:0] HUNGER_MAX = HW'(HUNGER_LIMIT);

  logic [HW-1:0] hunger;
  logic          externVorrang;

  // Pick the winner: a starved external master overrides the fixed order.
  always_comb begin
    externVorrang = ExternAnfrage && (hunger == HUNGER_MAX);
    GrantGueltig  = Arbitrieren && (BefehlAnfrage || DatenLadeAnfrage ||
                                    DatenSpeicherAnfrage || ExternAnfrage);
    Gewinner      = BEFEHL;
    if (externVorrang)             Gewinner = EXTERN;
    else if (DatenSpeicherAnfrage) Gewinner = DATEN_SPEICHERN;
    else if (DatenLadeAnfrage)     Gewinner = DATEN_LADEN;
    else if (BefehlAnfrage)        Gewinner = BEFEHL;
    else if (ExternAnfrage)        Gewinner = EXTERN;
  end

  // Count arbitrations the external master loses; saturate at the limit.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      hunger <= '0;
    end else if (Arbitrieren) begin
      if (!ExternAnfrage || (GrantGueltig && (Gewinner == EXTERN))) begin
        hunger <= '0;
      end else if (hunger != HUNGER_MAX) begin
        hunger <= hunger + 1'b1;
      end
    end
  end

endmodule

// File: rtl/speicher_arbiter.sv
// Shares the single memory port between instruction fetch, data load/store
// and an external master. One transaction in flight; done pulses per source.
module speicher_arbiter
  import speicher_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int TIMEOUT_ZYKLEN = 1023,
  parameter int HUNGER_LIMIT   = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    BefehlAnfrage,
  input  logic [ADDR_WIDTH-1:0]   BefehlAdresse,
  output logic [DATA_WIDTH-1:0]   BefehlDaten,
  output logic                    BefehlGeladen,
  input  logic                    DatenLadeAnfrage,
  input  logic                    DatenSpeicherAnfrage,
  input  logic [ADDR_WIDTH-1:0]   DatenAdresse,
  input  logic [DATA_WIDTH-1:0]   DatenSchreibwert,
  input  logic [DATA_WIDTH/8-1:0] DatenMaske,
  output logic [DATA_WIDTH-1:0]   DatenGelesen,
  output logic                    DatenGeladen,
  output logic                    DatenGespeichert,
  input  logic                    ExternAnfrage,
  input  logic                    ExternSchreiben,
  input  logic [ADDR_WIDTH-1:0]   ExternAdresse,
  input  logic [DATA_WIDTH-1:0]   ExternSchreibwert,
  input  logic [DATA_WIDTH/8-1:0] ExternMaske,
  output logic [DATA_WIDTH-1:0]   ExternLesewert,
  output logic                    ExternFertig,
  output logic                    SpeicherAnfrage,
  output logic                    SpeicherSchreiben,
  output logic [ADDR_WIDTH-1:0]   SpeicherAdresse,
  output logic [DATA_WIDTH-1:0]   SpeicherSchreibwert,
  output logic [DATA_WIDTH/8-1:0] SpeicherMaske,
  input  logic [DATA_WIDTH-1:0]   SpeicherLesewert,
  input  logic                    SpeicherBereit,
  output logic                    Zeitueberschreitung
);

  localparam int TW = (TIMEOUT_ZYKLEN < 2) ? 1 : $clog2(TIMEOUT_ZYKLEN);
  localparam logic [TW-1:0] ZEIT_LETZTER =
    TW'((TIMEOUT_ZYKLEN < 1) ? 0 : TIMEOUT_ZYKLEN - 1);

  zustand_t              zustand;
  anfrager_t             besitzer;
  anfrager_t             gewinner;
  logic                  grantGueltig;
  logic [TW-1:0]         zeitZaehler;
  logic                  abbruch;
  logic                  abschluss;
  logic [DATA_WIDTH-1:0] lesewert;

  speicher_prioritaet #(
    .HUNGER_LIMIT(HUNGER_LIMIT)
  ) uPrioritaet (
    .Clock               (Clock),
    .Reset               (Reset),
    .Arbitrieren         (zustand == IDLE),
    .BefehlAnfrage       (BefehlAnfrage),
    .DatenLadeAnfrage    (DatenLadeAnfrage),
    .DatenSpeicherAnfrage(DatenSpeicherAnfrage),
    .ExternAnfrage       (ExternAnfrage),
    .Gewinner            (gewinner),
    .GrantGueltig        (grantGueltig)
  );

  // Completion decision for the BUSY state; an aborted read returns zero.
  always_comb begin
    abbruch   = (TIMEOUT_ZYKLEN != 0) && !SpeicherBereit &&
                (zeitZaehler == ZEIT_LETZTER);
    abschluss = SpeicherBereit || abbruch;
    lesewert  = SpeicherBereit ? SpeicherLesewert : '0;
  end

  // Transaction FSM: latch the grant, hold the memory request, pulse done.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      zustand             <= IDLE;
      besitzer            <= BEFEHL;
      zeitZaehler         <= '0;
      SpeicherAnfrage     <= 1'b0;
      SpeicherSchreiben   <= 1'b0;
      SpeicherAdresse     <= '0;
      SpeicherSchreibwert <= '0;
      SpeicherMaske       <= '0;
      BefehlDaten         <= '0;
      DatenGelesen        <= '0;
      ExternLesewert      <= '0;
      BefehlGeladen       <= 1'b0;
      DatenGeladen        <= 1'b0;
      DatenGespeichert    <= 1'b0;
      ExternFertig        <= 1'b0;
      Zeitueberschreitung <= 1'b0;
    end else begin
      BefehlGeladen       <= 1'b0;
      DatenGeladen        <= 1'b0;
      DatenGespeichert    <= 1'b0;
      ExternFertig        <= 1'b0;
      Zeitueberschreitung <= 1'b0;
      case (zustand)
        IDLE: begin
          if (grantGueltig) begin
            zustand         <= BUSY;
            besitzer        <= gewinner;
            zeitZaehler     <= '0;
            SpeicherAnfrage <= 1'b1;
            case (gewinner)
              BEFEHL: begin
                SpeicherAdresse     <= BefehlAdresse;
                SpeicherSchreiben   <= 1'b0;
                SpeicherSchreibwert <= '0;
                SpeicherMaske       <= '1;
              end
              DATEN_LADEN: begin
                SpeicherAdresse     <= DatenAdresse;
                SpeicherSchreiben   <= 1'b0;
                SpeicherSchreibwert <= '0;
                SpeicherMaske       <= '1;
              end
              DATEN_SPEICHERN: begin
                SpeicherAdresse     <= DatenAdresse;
                SpeicherSchreiben   <= 1'b1;
                SpeicherSchreibwert <= DatenSchreibwert;
                SpeicherMaske       <= DatenMaske;
              end
              EXTERN: begin
                SpeicherAdresse     <= ExternAdresse;
                SpeicherSchreiben   <= ExternSchreiben;
                SpeicherSchreibwert <= ExternSchreiben ? ExternSchreibwert : '0;
                SpeicherMaske       <= ExternSchreiben ? ExternMaske : '1;
              end
            endcase
          end
        end
        BUSY: begin
          if (abschluss) begin
            zustand             <= FERTIG;
            SpeicherAnfrage     <= 1'b0;
            SpeicherSchreiben   <= 1'b0;
            Zeitueberschreitung <= abbruch;
            case (besitzer)
              BEFEHL: begin
                BefehlDaten   <= lesewert;
                BefehlGeladen <= 1'b1;
              end
              DATEN_LADEN: begin
                DatenGelesen <= lesewert;
                DatenGeladen <= 1'b1;
              end
              DATEN_SPEICHERN: begin
                DatenGespeichert <= 1'b1;
              end
              EXTERN: begin
                if (!SpeicherSchreiben) ExternLesewert <= lesewert;
                ExternFertig <= 1'b1;
              end
            endcase
          end else begin
            zeitZaehler <= zeitZaehler + 1'b1;
          end
        end
        FERTIG: begin
          zustand <= IDLE;
        end
        default: begin
          zustand <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speicher_arbiter.sv
// Randomized transaction-level bench for speicher_arbiter with a reference
// model of priority, starvation and timeout rules.
module tb_speicher_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 8;
  localparam int HL = 4;

  localparam int W_BEF = 0;
  localparam int W_LAD = 1;
  localparam int W_SPE = 2;
  localparam int W_EXT = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          BefehlAnfrage = 1'b0;
  logic [AW-1:0] BefehlAdresse = '0;
  logic [DW-1:0] BefehlDaten;
  logic          BefehlGeladen;
  logic          DatenLadeAnfrage = 1'b0;
  logic          DatenSpeicherAnfrage = 1'b0;
  logic [AW-1:0] DatenAdresse = '0;
  logic [DW-1:0] DatenSchreibwert = '0;
  logic [MW-1:0] DatenMaske = '0;
  logic [DW-1:0] DatenGelesen;
  logic          DatenGeladen;
  logic          DatenGespeichert;
  logic          ExternAnfrage = 1'b0;
  logic          ExternSchreiben = 1'b0;
  logic [AW-1:0] ExternAdresse = '0;
  logic [DW-1:0] ExternSchreibwert = '0;
  logic [MW-1:0] ExternMaske = '0;
  logic [DW-1:0] ExternLesewert;
  logic          ExternFertig;
  logic          SpeicherAnfrage;
  logic          SpeicherSchreiben;
  logic [AW-1:0] SpeicherAdresse;
  logic [DW-1:0] SpeicherSchreibwert;
  logic [MW-1:0] SpeicherMaske;
  logic [DW-1:0] SpeicherLesewert = '0;
  logic          SpeicherBereit = 1'b0;
  logic          Zeitueberschreitung;

  logic [4:0] pulse;
  assign pulse = {BefehlGeladen, DatenGeladen, DatenGespeichert, ExternFertig, Zeitueberschreitung};

  speicher_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_ZYKLEN(TO),
    .HUNGER_LIMIT  (HL)
  ) dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .BefehlAnfrage       (BefehlAnfrage),
    .BefehlAdresse       (BefehlAdresse),
    .BefehlDaten         (BefehlDaten),
    .BefehlGeladen       (BefehlGeladen),
    .DatenLadeAnfrage    (DatenLadeAnfrage),
    .DatenSpeicherAnfrage(DatenSpeicherAnfrage),
    .DatenAdresse        (DatenAdresse),
    .DatenSchreibwert    (DatenSchreibwert),
    .DatenMaske          (DatenMaske),
    .DatenGelesen        (DatenGelesen),
    .DatenGeladen        (DatenGeladen),
    .DatenGespeichert    (DatenGespeichert),
    .ExternAnfrage       (ExternAnfrage),
    .ExternSchreiben     (ExternSchreiben),
    .ExternAdresse       (ExternAdresse),
    .ExternSchreibwert   (ExternSchreibwert),
    .ExternMaske         (ExternMaske),
    .ExternLesewert      (ExternLesewert),
    .ExternFertig        (ExternFertig),
    .SpeicherAnfrage     (SpeicherAnfrage),
    .SpeicherSchreiben   (SpeicherSchreiben),
    .SpeicherAdresse     (SpeicherAdresse),
    .SpeicherSchreibwert (SpeicherSchreibwert),
    .SpeicherMaske       (SpeicherMaske),
    .SpeicherLesewert    (SpeicherLesewert),
    .SpeicherBereit      (SpeicherBereit),
    .Zeitueberschreitung (Zeitueberschreitung)
  );

  always #5 Clock = ~Clock;

  int            anzahlVergleiche = 0;
  int            anzahlFehler = 0;
  int            hungerModell = 0;
  logic [DW-1:0] befehlSoll = '0;
  logic [DW-1:0] datenSoll = '0;
  logic [DW-1:0] externSoll = '0;
  bit            inFertig = 1'b0;

  task automatic pruefe(input string tag, input logic [63:0] ist, input logic [63:0] soll);
    anzahlVergleiche++;
    if (ist !== soll) begin
      anzahlFehler++;
      $display("FAIL %s: ist=0x%0h soll=0x%0h (t=%0t)", tag, ist, soll, $time);
    end
  endtask

  task automatic anfragen(input logic b, input logic l, input logic s, input logic e, input logic w);
    BefehlAnfrage        = b;
    DatenLadeAnfrage     = l;
    DatenSpeicherAnfrage = s;
    ExternAnfrage        = e;
    ExternSchreiben      = w;
  endtask

  task automatic zufallsFelder();
    BefehlAdresse     = $urandom;
    DatenAdresse      = $urandom;
    DatenSchreibwert  = $urandom;
    DatenMaske        = MW'($urandom);
    ExternAdresse     = $urandom;
    ExternSchreibwert = $urandom;
    ExternMaske       = MW'($urandom);
  endtask

  task automatic pruefeNull(input string tag);
    pruefe({tag, "_anfrage"},  64'(SpeicherAnfrage), 64'(0));
    pruefe({tag, "_schreiben"}, 64'(SpeicherSchreiben), 64'(0));
    pruefe({tag, "_adresse"},  64'(SpeicherAdresse), 64'(0));
    pruefe({tag, "_wert"},     64'(SpeicherSchreibwert), 64'(0));
    pruefe({tag, "_maske"},    64'(SpeicherMaske), 64'(0));
    pruefe({tag, "_befehl"},   64'(BefehlDaten), 64'(0));
    pruefe({tag, "_daten"},    64'(DatenGelesen), 64'(0));
    pruefe({tag, "_extern"},   64'(ExternLesewert), 64'(0));
    pruefe({tag, "_pulse"},    64'(pulse), 64'(0));
  endtask

  task automatic pruefeBusy(input string tag, input logic [AW-1:0] adr, input logic [DW-1:0] wert,
                            input logic wr, input logic [MW-1:0] msk);
    pruefe({tag, "_anfrage"},   64'(SpeicherAnfrage), 64'(1));
    pruefe({tag, "_schreiben"}, 64'(SpeicherSchreiben), 64'(wr));
    pruefe({tag, "_adresse"},   64'(SpeicherAdresse), 64'(adr));
    if (wr) pruefe({tag, "_wert"}, 64'(SpeicherSchreibwert), 64'(wert));
    pruefe({tag, "_maske"},     64'(SpeicherMaske), 64'(msk));
    pruefe({tag, "_pulse"},     64'(pulse), 64'(0));
  endtask

  task automatic resetSequenz();
    Reset = 1'b0;
    anfragen(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    SpeicherBereit = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    pruefeNull("reset");
    Reset        = 1'b1;
    hungerModell = 0;
    befehlSoll   = '0;
    datenSoll    = '0;
    externSoll   = '0;
    inFertig     = 1'b0;
  endtask

  // One complete transaction using the request inputs currently driven.
  // warte = cycles without SpeicherBereit; warte >= TO means never ready.
  task automatic runde(input int warte, input logic [DW-1:0] lese);
    logic          b, l, s, e, w, timeout;
    int            sieger, nNiedrig;
    logic [AW-1:0] adrSoll;
    logic [DW-1:0] wertSoll, ergebnis;
    logic          wrSoll;
    logic [MW-1:0] mskSoll;
    logic [4:0]    pulsSoll;
    b = BefehlAnfrage; l = DatenLadeAnfrage; s = DatenSpeicherAnfrage;
    e = ExternAnfrage; w = ExternSchreiben;
    if (inFertig) begin
      @(posedge Clock); #1;
      pruefe("fertig_einzyklus", 64'(pulse), 64'(0));
      pruefe("fertig_keingrant", 64'(SpeicherAnfrage), 64'(0));
      inFertig = 1'b0;
    end
    if (!(b || l || s || e)) begin
      hungerModell = 0;
      @(posedge Clock); #1;
      pruefe("idle_anfrage", 64'(SpeicherAnfrage), 64'(0));
      pruefe("idle_pulse", 64'(pulse), 64'(0));
      return;
    end
    if (e && hungerModell == HL) sieger = W_EXT;
    else if (s)                  sieger = W_SPE;
    else if (l)                  sieger = W_LAD;
    else if (b)                  sieger = W_BEF;
    else                         sieger = W_EXT;
    if (sieger == W_EXT || !e) hungerModell = 0;
    else if (hungerModell < HL) hungerModell = hungerModell + 1;
    wertSoll = '0;
    mskSoll  = '1;
    wrSoll   = 1'b0;
    case (sieger)
      W_BEF: adrSoll = BefehlAdresse;
      W_LAD: adrSoll = DatenAdresse;
      W_SPE: begin
        adrSoll = DatenAdresse; wrSoll = 1'b1;
        wertSoll = DatenSchreibwert; mskSoll = DatenMaske;
      end
      default: begin
        adrSoll = ExternAdresse; wrSoll = w;
        if (w) begin wertSoll = ExternSchreibwert; mskSoll = ExternMaske; end
      end
    endcase
    @(posedge Clock); #1;
    pruefeBusy("grant", adrSoll, wertSoll, wrSoll, mskSoll);
    // Inputs wander during BUSY; the latched transaction must not follow.
    zufallsFelder();
    anfragen(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    timeout  = (warte >= TO);
    nNiedrig = timeout ? TO : warte;
    for (int i = 0; i < nNiedrig; i++) begin
      SpeicherBereit   = 1'b0;
      SpeicherLesewert = $urandom;
      @(posedge Clock); #1;
      if (!(timeout && i == nNiedrig - 1)) pruefeBusy("halt", adrSoll, wertSoll, wrSoll, mskSoll);
    end
    if (!timeout) begin
      SpeicherBereit   = 1'b1;
      SpeicherLesewert = lese;
      @(posedge Clock); #1;
      SpeicherBereit   = 1'b0;
    end
    ergebnis = timeout ? '0 : lese;
    pulsSoll = {4'b0000, timeout};
    case (sieger)
      W_BEF: begin pulsSoll[4] = 1'b1; befehlSoll = ergebnis; end
      W_LAD: begin pulsSoll[3] = 1'b1; datenSoll = ergebnis; end
      W_SPE: pulsSoll[2] = 1'b1;
      default: begin pulsSoll[1] = 1'b1; if (!w) externSoll = ergebnis; end
    endcase
    pruefe("fertig_pulse",   64'(pulse), 64'(pulsSoll));
    pruefe("fertig_anfrage", 64'(SpeicherAnfrage), 64'(0));
    pruefe("befehl_daten",   64'(BefehlDaten), 64'(befehlSoll));
    pruefe("daten_gelesen",  64'(DatenGelesen), 64'(datenSoll));
    pruefe("extern_lese",    64'(ExternLesewert), 64'(externSoll));
    inFertig = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: ist=running soll=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    resetSequenz();

    // Fetch with zero-wait memory
    zufallsFelder();
    BefehlAdresse = 32'h0000_0100;
    anfragen(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runde(0, 32'hDEAD_BEEF);

    // Store with five wait cycles
    zufallsFelder();
    DatenAdresse     = 32'h0000_0020;
    DatenSchreibwert = 32'h1234_5678;
    DatenMaske       = 4'h3;
    anfragen(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    runde(5, 32'hCAFE_F00D);

    // Starvation: fetch keeps re-requesting against a waiting external read
    resetSequenz();
    for (int k = 0; k < 10; k++) begin
      zufallsFelder();
      anfragen(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      runde($urandom_range(0, 2), $urandom);
    end

    // Load timeout
    zufallsFelder();
    anfragen(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runde(TO, 32'h5555_AAAA);

    // Load and store together: store first, then the load
    zufallsFelder();
    anfragen(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runde(1, $urandom);
    zufallsFelder();
    anfragen(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runde(0, 32'hA5A5_0F0F);

    // Reset during the third BUSY cycle, with memory ready at the same edge
    resetSequenz();
    zufallsFelder();
    anfragen(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge Clock); #1;
    pruefe("rb_grant", 64'(SpeicherAnfrage), 64'(1));
    anfragen(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset            = 1'b0;
    SpeicherBereit   = 1'b1;
    SpeicherLesewert = 32'hFFFF_FFFF;
    @(posedge Clock); #1;
    SpeicherBereit = 1'b0;
    pruefeNull("rb");
    Reset = 1'b1;
    hungerModell = 0;
    @(posedge Clock); #1;
    pruefe("rb_kein_puls", 64'(pulse), 64'(0));
    pruefe("rb_idle", 64'(SpeicherAnfrage), 64'(0));

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      zufallsFelder();
      anfragen(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) < 3),
               1'($urandom_range(0, 1)));
      runde($urandom_range(0, 9), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", anzahlVergleiche, anzahlFehler);
    $finish;
  end

endmodule

// File: doc/speicher_arbiter.md
Name: speicher_arbiter

Overview:
Shares the single memory port between three requesters: instruction fetch and data load/store from the processor control FSM, and an external master (debugger/DMA). Sits between the control/datapath and the memory interface. It returns the BefehlGeladen, DatenGeladen and DatenGespeichert handshakes that the control FSM waits on. One transaction is in flight at a time.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; mask width is DATA_WIDTH/8
TIMEOUT_ZYKLEN, 1023, max BUSY cycles before abort; 0 disables timeout
HUNGER_LIMIT, 4, lost arbitrations after which Extern gets top priority

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
BefehlAnfrage  in  1  level fetch request
BefehlAdresse  in  ADDR_WIDTH  fetch address
BefehlDaten  out  DATA_WIDTH  fetched instruction, held until next fetch completes
BefehlGeladen  out  1  1-cycle done pulse
DatenLadeAnfrage  in  1  level load request
DatenSpeicherAnfrage  in  1  level store request
DatenAdresse  in  ADDR_WIDTH  load/store address
DatenSchreibwert  in  DATA_WIDTH  store data
DatenMaske  in  DATA_WIDTH/8  store byte enables
DatenGelesen  out  DATA_WIDTH  load result, held until next load completes
DatenGeladen  out  1  1-cycle load done pulse
DatenGespeichert  out  1  1-cycle store done pulse
ExternAnfrage  in  1  level external request
ExternSchreiben  in  1  1 = write, 0 = read
ExternAdresse  in  ADDR_WIDTH  external address
ExternSchreibwert  in  DATA_WIDTH  external write data
ExternMaske  in  DATA_WIDTH/8  external byte enables
ExternLesewert  out  DATA_WIDTH  external read result, held
ExternFertig  out  1  1-cycle done pulse
SpeicherAnfrage  out  1  memory request, held until SpeicherBereit
SpeicherSchreiben  out  1  memory write enable
SpeicherAdresse  out  ADDR_WIDTH  memory address
SpeicherSchreibwert  out  DATA_WIDTH  memory write data
SpeicherMaske  out  DATA_WIDTH/8  byte enables; all ones for reads
SpeicherLesewert  in  DATA_WIDTH  memory read data, valid with SpeicherBereit
SpeicherBereit  in  1  memory completes current request
Zeitueberschreitung  out  1  1-cycle pulse on timeout abort

Behaviour:
- Reset (Reset=0 at a clock edge): state IDLE. All pulses, SpeicherAnfrage and SpeicherSchreiben = 0. All data, address and mask outputs = 0. Hunger and timeout counters = 0. A transaction in flight is abandoned with no done pulse.
- States: IDLE, BUSY, FERTIG.
- IDLE: chooses the winner. Priority order is DatenSpeicherAnfrage > DatenLadeAnfrage > BefehlAnfrage > ExternAnfrage. If the hunger counter equals HUNGER_LIMIT and Extern is requesting, Extern wins. On a grant, address, write data, mask, direction and requester ID are latched, and the state moves to BUSY. With no request, the state stays in IDLE.
- Hunger counter:
  - +1 on each grant where ExternAnfrage=1 and Extern lost.
  - Cleared when Extern is granted, or in IDLE when ExternAnfrage=0.
  - Saturates at HUNGER_LIMIT.
- BUSY: SpeicherAnfrage=1 and the Speicher* outputs are driven from the latches and stay stable. The timeout counter increments each BUSY cycle.
  - SpeicherBereit=1: capture SpeicherLesewert into the winner's read register (reads only), go to FERTIG.
  - Counter reaches TIMEOUT_ZYKLEN (≠0) without SpeicherBereit: the winner's read register is set to 0, Zeitueberschreitung=1 in the FERTIG cycle, go to FERTIG.
- FERTIG: SpeicherAnfrage=0; the winner's done pulse is high for exactly this cycle; the next state is IDLE. No arbitration happens in FERTIG, so a requester that drops its request after the pulse is never granted twice.
- Latency:
  - Request sampled in IDLE at cycle n → SpeicherAnfrage=1 at n+1.
  - SpeicherBereit sampled at cycle m → done pulse at m+1, IDLE at m+2.
  - Zero-wait memory: done at n+2.
- Requests withdrawn during BUSY: the transaction completes and the done pulse is still issued.
- Request inputs changing during BUSY do not affect the latched transaction.
- Both data requests high together: the store is served first.

Decomposition:
- Package speicher_pkg holds: state encodings (IDLE/BUSY/FERTIG), requester ID constants (BEFEHL, DATEN_LADEN, DATEN_SPEICHERN, EXTERN), and the default width constants.
- Sub-module speicher_prioritaet contains the combinational priority selection plus the hunger counter. It outputs the winner ID and a grant-valid signal.
- The FSM, latches, timeout counter and read registers stay in speicher_arbiter.

Test Plan:
- Fetch: BefehlAnfrage=1, BefehlAdresse=0x100, memory returns 0xDEADBEEF with Bereit in the 1st BUSY cycle → BefehlDaten=0xDEADBEEF, BefehlGeladen pulses at n+2 for 1 cycle, SpeicherMaske=0xF, SpeicherSchreiben=0.
- Store: DatenSpeicherAnfrage=1, addr 0x20, data 0x12345678, mask 0x3, memory waits 5 cycles → Speicher* stable for all 5 cycles, DatenGespeichert pulses once, DatenGelesen unchanged.
- Arbitration and starvation: ExternAnfrage held high while BefehlAnfrage re-asserts after every pulse, HUNGER_LIMIT=4 → Befehl granted 4 times, then Extern granted, then the counter is back at 0.
- Timeout: TIMEOUT_ZYKLEN=8, DatenLadeAnfrage=1, SpeicherBereit never set → SpeicherAnfrage high for 8 cycles, then Zeitueberschreitung and DatenGeladen pulse together, DatenGelesen=0.
- Reset mid-BUSY: Reset=0 during the 3rd BUSY cycle → next cycle SpeicherAnfrage=0, state IDLE, no done pulse, all outputs 0.
- Simultaneous data requests: load and store both high → the store completes first, then the load is granted in the next IDLE.
